// File: rtl/framebuf_pkg.sv
// Shared definitions for the ping-pong frame buffer: FSM states, default
// geometry and the {bank, address} physical-address helper.
package framebuf_pkg;

   localparam int FB_DEFAULT_DATA_W = 16;
   localparam int FB_DEFAULT_ADDR_W = 13;
   // Widest per-bank address the helper function can carry.
   localparam int FB_MAX_ADDR_W     = 24;

   typedef enum logic [1:0] {
      FB_IDLE    = 2'd0,
      FB_PENDING = 2'd1,
      FB_CLEAR   = 2'd2
   } fb_state_t;

   // Builds {bank, addr} for a bank of 2^addr_w words. The caller truncates
   // the result to addr_w+1 bits.
   function automatic logic [FB_MAX_ADDR_W:0] fb_bank_addr(
      input logic                     bank,
      input logic [FB_MAX_ADDR_W-1:0] addr,
      input int unsigned              addr_w
   );
      logic [FB_MAX_ADDR_W:0] w_bank_ext;
      w_bank_ext = {{FB_MAX_ADDR_W{1'b0}}, bank};
      return (w_bank_ext << addr_w) | {1'b0, addr};
   endfunction

endpackage

// File: rtl/framebuf_tdp_ram.sv
// Dual-port block RAM holding both frame banks. Port A reads and writes with
// byte enables (read-first: a read of the address being written returns the
// old word); port B is read-only. Both read outputs are registered, reset to
// zero, and hold their value when no read is issued.
module framebuf_tdp_ram #(
   parameter  int DATA_W = 16,
   parameter  int ADDR_W = 14,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_a_we,
   input  logic              i_a_re,
   input  logic [BE_W-1:0]   i_a_be,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [DATA_W-1:0] i_a_wdata,
   output logic [DATA_W-1:0] o_a_rdata,
   input  logic              i_b_re,
   input  logic [ADDR_W-1:0] i_b_addr,
   output logic [DATA_W-1:0] o_b_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;

   // Port A byte-lane write; the array itself is never reset.
   always_ff @(posedge i_clk) begin
      if (i_a_we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (i_a_be[i]) begin
               r_mem[i_a_addr][i*8 +: 8] <= i_a_wdata[i*8 +: 8];
            end
         end
      end
   end

   // Port A registered read (old data on same-address write).
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a_rdata <= '0;
      end else if (i_a_re) begin
         r_a_rdata <= r_mem[i_a_addr];
      end
   end

   // Port B registered read.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_b_rdata <= '0;
      end else if (i_b_re) begin
         r_b_rdata <= r_mem[i_b_addr];
      end
   end

   assign o_a_rdata = r_a_rdata;
   assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/framebuf_pingpong.sv
// Double-buffered voxel frame buffer. s1 (renderer) accesses the back bank,
// s2 (scanner) reads the front bank. A swap request is held until the
// scanner's frame_done so a displayed frame is never torn.
// Optional feature macro FRAMEBUF_CLEAR_EN: after each swap the new back bank
// is zero-filled one word per cycle while s1 is stalled with waitrequest.
module framebuf_pingpong
   import framebuf_pkg::*;
#(
   parameter  int DATA_W = FB_DEFAULT_DATA_W,
   parameter  int ADDR_W = FB_DEFAULT_ADDR_W,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s1_address,
   input  logic              s1_chipselect,
   input  logic              s1_write,
   input  logic              s1_read,
   input  logic [BE_W-1:0]   s1_byteenable,
   input  logic [DATA_W-1:0] s1_writedata,
   output logic [DATA_W-1:0] s1_readdata,
   output logic              s1_readdatavalid,
   output logic              s1_waitrequest,
   input  logic [ADDR_W-1:0] s2_address,
   input  logic              s2_chipselect,
   input  logic              s2_read,
   output logic [DATA_W-1:0] s2_readdata,
   output logic              s2_readdatavalid,
   input  logic              swap_req,
   input  logic              frame_done,
   output logic              swap_busy,
   output logic              swap_done,
   output logic              front_bank
);

   fb_state_t r_state, w_state_next;
   logic      r_front_bank, w_front_bank_next;
   logic      r_swap_done, w_swap_done_next;
   logic      r_s1_rdv, r_s2_rdv;

   logic      w_s1_wait;
   logic      w_map_front;
   logic      w_s1_wr_acc, w_s1_rd_acc, w_s2_rd_acc;

   logic              w_a_we;
   logic [BE_W-1:0]   w_a_be;
   logic [DATA_W-1:0] w_a_wdata;
   logic [ADDR_W:0]   w_a_addr;
   logic [ADDR_W:0]   w_b_addr;

`ifdef FRAMEBUF_CLEAR_EN
   logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_next;
   assign w_s1_wait = (r_state == FB_CLEAR);
`else
   assign w_s1_wait = 1'b0;
`endif

   // In the swap_done cycle front_bank has already toggled, but commands
   // accepted then must still see the previous mapping.
   assign w_map_front = r_front_bank ^ r_swap_done;

   assign w_s1_wr_acc = s1_chipselect & ~w_s1_wait & s1_write;
   assign w_s1_rd_acc = s1_chipselect & ~w_s1_wait & s1_read & ~s1_write;
   assign w_s2_rd_acc = s2_chipselect & s2_read;

   assign w_b_addr = (ADDR_W+1)'(fb_bank_addr(w_map_front,
                        FB_MAX_ADDR_W'(s2_address), ADDR_W));

   // Port A source: renderer write, or the zero-fill engine while clearing.
   always_comb begin
      w_a_we    = w_s1_wr_acc;
      w_a_be    = s1_byteenable;
      w_a_wdata = s1_writedata;
      w_a_addr  = (ADDR_W+1)'(fb_bank_addr(~w_map_front,
                     FB_MAX_ADDR_W'(s1_address), ADDR_W));
`ifdef FRAMEBUF_CLEAR_EN
      if (r_state == FB_CLEAR) begin
         w_a_we    = 1'b1;
         w_a_be    = '1;
         w_a_wdata = '0;
         w_a_addr  = (ADDR_W+1)'(fb_bank_addr(~r_front_bank,
                        FB_MAX_ADDR_W'(r_clr_cnt), ADDR_W));
      end
`endif
   end

   // Swap FSM next-state: request capture, frame-boundary toggle, clear.
   always_comb begin
      w_state_next      = r_state;
      w_front_bank_next = r_front_bank;
      w_swap_done_next  = 1'b0;
`ifdef FRAMEBUF_CLEAR_EN
      w_clr_cnt_next    = r_clr_cnt;
`endif
      case (r_state)
         FB_IDLE: begin
            if (swap_req) begin
               w_state_next = FB_PENDING;
            end
         end
         FB_PENDING: begin
            if (frame_done) begin
               w_front_bank_next = ~r_front_bank;
               w_swap_done_next  = 1'b1;
`ifdef FRAMEBUF_CLEAR_EN
               w_state_next      = FB_CLEAR;
               w_clr_cnt_next    = '0;
`else
               w_state_next      = FB_IDLE;
`endif
            end
         end
`ifdef FRAMEBUF_CLEAR_EN
         FB_CLEAR: begin
            w_clr_cnt_next = r_clr_cnt + 1'b1;
            if (&r_clr_cnt) begin
               w_state_next = FB_IDLE;
            end
         end
`endif
         default: begin
            w_state_next = FB_IDLE;
         end
      endcase
   end

   // State, bank pointer, swap pulse and read-valid registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= FB_IDLE;
         r_front_bank <= 1'b0;
         r_swap_done  <= 1'b0;
         r_s1_rdv     <= 1'b0;
         r_s2_rdv     <= 1'b0;
`ifdef FRAMEBUF_CLEAR_EN
         r_clr_cnt    <= '0;
`endif
      end else begin
         r_state      <= w_state_next;
         r_front_bank <= w_front_bank_next;
         r_swap_done  <= w_swap_done_next;
         r_s1_rdv     <= w_s1_rd_acc;
         r_s2_rdv     <= w_s2_rd_acc;
`ifdef FRAMEBUF_CLEAR_EN
         r_clr_cnt    <= w_clr_cnt_next;
`endif
      end
   end

   framebuf_tdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W + 1)
   ) u_ram (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_a_we    (w_a_we),
      .i_a_re    (w_s1_rd_acc),
      .i_a_be    (w_a_be),
      .i_a_addr  (w_a_addr),
      .i_a_wdata (w_a_wdata),
      .o_a_rdata (s1_readdata),
      .i_b_re    (w_s2_rd_acc),
      .i_b_addr  (w_b_addr),
      .o_b_rdata (s2_readdata)
   );

   assign s1_readdatavalid = r_s1_rdv;
   assign s2_readdatavalid = r_s2_rdv;
   assign s1_waitrequest   = w_s1_wait;
   assign swap_busy        = (r_state != FB_IDLE);
   assign swap_done        = r_swap_done;
   assign front_bank       = r_front_bank;

endmodule

// File: tb/tb_framebuf_pingpong.sv
// Directed self-checking bench for framebuf_pingpong (DATA_W=16, ADDR_W=4).
// Clear-specific scenarios are built only when FRAMEBUF_CLEAR_EN is defined.
module tb_framebuf_pingpong;

   localparam int DW = 16;
   localparam int AW = 4;
`ifdef FRAMEBUF_CLEAR_EN
   localparam int  EXP_CLR  = 16;
   localparam int  EXP_CLR1 = 15;
   localparam logic EXP_BUSY_AFTER = 1'b1;
   localparam logic EXP_WAIT_AFTER = 1'b1;
`else
   localparam int  EXP_CLR  = 0;
   localparam int  EXP_CLR1 = 0;
   localparam logic EXP_BUSY_AFTER = 1'b0;
   localparam logic EXP_WAIT_AFTER = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] s1_address;
   logic          s1_chipselect, s1_write, s1_read;
   logic [1:0]    s1_byteenable;
   logic [DW-1:0] s1_writedata;
   logic [DW-1:0] s1_readdata;
   logic          s1_readdatavalid, s1_waitrequest;
   logic [AW-1:0] s2_address;
   logic          s2_chipselect, s2_read;
   logic [DW-1:0] s2_readdata;
   logic          s2_readdatavalid;
   logic          swap_req, frame_done;
   logic          swap_busy, swap_done, front_bank;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   framebuf_pingpong #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk              (clk),
      .reset            (reset),
      .s1_address       (s1_address),
      .s1_chipselect    (s1_chipselect),
      .s1_write         (s1_write),
      .s1_read          (s1_read),
      .s1_byteenable    (s1_byteenable),
      .s1_writedata     (s1_writedata),
      .s1_readdata      (s1_readdata),
      .s1_readdatavalid (s1_readdatavalid),
      .s1_waitrequest   (s1_waitrequest),
      .s2_address       (s2_address),
      .s2_chipselect    (s2_chipselect),
      .s2_read          (s2_read),
      .s2_readdata      (s2_readdata),
      .s2_readdatavalid (s2_readdatavalid),
      .swap_req         (swap_req),
      .frame_done       (frame_done),
      .swap_busy        (swap_busy),
      .swap_done        (swap_done),
      .front_bank       (front_bank)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic s1_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
      s1_address = a; s1_writedata = d; s1_byteenable = be;
      s1_chipselect = 1'b1; s1_write = 1'b1;
      tick();
      s1_chipselect = 1'b0; s1_write = 1'b0;
      $display("[TB] s1 write addr=%0d data=%h be=%b", a, d, be);
   endtask

   task automatic s1_rd(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d);
      s1_address = a; s1_chipselect = 1'b1; s1_read = 1'b1;
      tick();
      s1_chipselect = 1'b0; s1_read = 1'b0;
      v = s1_readdatavalid; d = s1_readdata;
      $display("[TB] s1 read  addr=%0d data=%h valid=%b", a, d, v);
   endtask

   task automatic s2_rd(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d);
      s2_address = a; s2_chipselect = 1'b1; s2_read = 1'b1;
      tick();
      s2_chipselect = 1'b0; s2_read = 1'b0;
      v = s2_readdatavalid; d = s2_readdata;
      $display("[TB] s2 read  addr=%0d data=%h valid=%b", a, d, v);
   endtask

   // swap_req, two idle cycles, frame_done; returns sampled in the swap_done cycle
   task automatic do_swap();
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      tick(); tick();
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      $display("[TB] swap issued front_bank=%b swap_done=%b", front_bank, swap_done);
   endtask

   // Counts sampled cycles with waitrequest high, bounded at 64.
   task automatic wait_clear(output int cyc);
      cyc = 0;
      while (s1_waitrequest && cyc < 64) begin
         cyc++;
         tick();
      end
      $display("[TB] waitrequest high for %0d cycles", cyc);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      s1_address = '0; s1_chipselect = 0; s1_write = 0; s1_read = 0;
      s1_byteenable = '0; s1_writedata = '0;
      s2_address = '0; s2_chipselect = 0; s2_read = 0;
      swap_req = 0; frame_done = 0;
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      n_tests++; if (s1_readdata !== 16'h0) begin n_fail++; $display("FAIL rst_s1_readdata got=%h exp=0000", s1_readdata); end
      n_tests++; if (s2_readdata !== 16'h0) begin n_fail++; $display("FAIL rst_s2_readdata got=%h exp=0000", s2_readdata); end
      n_tests++; if (s1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_s1_rdv got=%b exp=0", s1_readdatavalid); end
      n_tests++; if (s2_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_s2_rdv got=%b exp=0", s2_readdatavalid); end
      n_tests++; if (s1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rst_waitreq got=%b exp=0", s1_waitrequest); end
      n_tests++; if (swap_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", swap_busy); end
      n_tests++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL rst_swap_done got=%b exp=0", swap_done); end
      n_tests++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL rst_front got=%b exp=0", front_bank); end
      $display("[TB] reset checked");
   endtask

   task automatic test_bank_isolation();
      logic v; logic [DW-1:0] d;
      s1_wr(4'd5, 16'hA5A5, 2'b11);
      s2_rd(4'd5, v, d);
      n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL iso_s2_rdv got=%b exp=1", v); end
      n_tests++; if (d === 16'hA5A5) begin n_fail++; $display("FAIL iso_s2_front got=%h exp=not a5a5", d); end
      s1_rd(4'd5, v, d);
      n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL iso_s1_rdv got=%b exp=1", v); end
      n_tests++; if (d !== 16'hA5A5) begin n_fail++; $display("FAIL iso_s1_data got=%h exp=a5a5", d); end
      tick();
      n_tests++; if (s1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL iso_rdv_drop got=%b exp=0", s1_readdatavalid); end
      n_tests++; if (s1_readdata !== 16'hA5A5) begin n_fail++; $display("FAIL iso_hold got=%h exp=a5a5", s1_readdata); end
   endtask

   task automatic test_swap();
      logic v; logic [DW-1:0] d; int cyc;
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      for (int i = 0; i < 9; i++) begin
         n_tests++; if (swap_busy !== 1'b1 || swap_done !== 1'b0) begin n_fail++; $display("FAIL swap_gap[%0d] busy=%b done=%b exp busy=1 done=0", i, swap_busy, swap_done); end
         tick();
      end
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      $display("[TB] frame_done front_bank=%b swap_done=%b", front_bank, swap_done);
      n_tests++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL swap_done_pulse got=%b exp=1", swap_done); end
      n_tests++; if (front_bank !== 1'b1) begin n_fail++; $display("FAIL swap_front got=%b exp=1", front_bank); end
      n_tests++; if (swap_busy !== EXP_BUSY_AFTER) begin n_fail++; $display("FAIL swap_busy_after got=%b exp=%b", swap_busy, EXP_BUSY_AFTER); end
      n_tests++; if (s1_waitrequest !== EXP_WAIT_AFTER) begin n_fail++; $display("FAIL swap_waitreq got=%b exp=%b", s1_waitrequest, EXP_WAIT_AFTER); end
      wait_clear(cyc);
      n_tests++; if (cyc !== EXP_CLR) begin n_fail++; $display("FAIL swap_clear_len got=%0d exp=%0d", cyc, EXP_CLR); end
      if (cyc == 0) tick();
      n_tests++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL swap_done_end got=%b exp=0", swap_done); end
      s2_rd(4'd5, v, d);
      n_tests++; if (d !== 16'hA5A5) begin n_fail++; $display("FAIL swap_s2_data got=%h exp=a5a5", d); end
   endtask

   task automatic test_byteenable();
      logic v; logic [DW-1:0] d;
      s1_wr(4'd7, 16'hA5A5, 2'b11);
      s1_wr(4'd7, 16'h1234, 2'b01);
      s1_rd(4'd7, v, d);
      n_tests++; if (d !== 16'hA534) begin n_fail++; $display("FAIL be_low got=%h exp=a534", d); end
      s1_wr(4'd7, 16'h5A00, 2'b10);
      s1_rd(4'd7, v, d);
      n_tests++; if (d !== 16'h5A34) begin n_fail++; $display("FAIL be_high got=%h exp=5a34", d); end
      // simultaneous write and read: write wins, read dropped
      s1_address = 4'd7; s1_writedata = 16'hFFFF; s1_byteenable = 2'b11;
      s1_chipselect = 1'b1; s1_write = 1'b1; s1_read = 1'b1;
      tick();
      s1_chipselect = 1'b0; s1_write = 1'b0; s1_read = 1'b0;
      $display("[TB] s1 write+read addr=7 valid=%b", s1_readdatavalid);
      n_tests++; if (s1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_drop got=%b exp=0", s1_readdatavalid); end
      s1_rd(4'd7, v, d);
      n_tests++; if (d !== 16'hFFFF) begin n_fail++; $display("FAIL wr_rd_data got=%h exp=ffff", d); end
      s1_wr(4'd9, 16'h2222, 2'b11);
   endtask

   task automatic test_same_cycle();
      int cyc;
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      $display("[TB] lone frame_done busy=%b done=%b", swap_busy, swap_done);
      n_tests++; if (swap_done !== 1'b0 || swap_busy !== 1'b0) begin n_fail++; $display("FAIL idle_fd done=%b busy=%b exp 0 0", swap_done, swap_busy); end
      swap_req = 1'b1; frame_done = 1'b1; tick(); swap_req = 1'b0; frame_done = 1'b0;
      $display("[TB] req+fd same cycle busy=%b done=%b front=%b", swap_busy, swap_done, front_bank);
      n_tests++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL same_done got=%b exp=0", swap_done); end
      n_tests++; if (swap_busy !== 1'b1) begin n_fail++; $display("FAIL same_busy got=%b exp=1", swap_busy); end
      n_tests++; if (front_bank !== 1'b1) begin n_fail++; $display("FAIL same_front got=%b exp=1", front_bank); end
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      n_tests++; if (swap_busy !== 1'b1 || front_bank !== 1'b1) begin n_fail++; $display("FAIL pend_req busy=%b front=%b exp 1 1", swap_busy, front_bank); end
      tick(); tick();
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      $display("[TB] next frame_done front=%b done=%b", front_bank, swap_done);
      n_tests++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL same_swap_done got=%b exp=1", swap_done); end
      n_tests++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL same_swap_front got=%b exp=0", front_bank); end
      wait_clear(cyc);
      n_tests++; if (cyc !== EXP_CLR) begin n_fail++; $display("FAIL same_clear_len got=%0d exp=%0d", cyc, EXP_CLR); end
      tick();
      n_tests++; if (swap_busy !== 1'b0) begin n_fail++; $display("FAIL same_idle got=%b exp=0", swap_busy); end
   endtask

   task automatic test_back_to_back();
      logic v; logic [DW-1:0] d; int cyc;
      s1_wr(4'd9, 16'h1111, 2'b11);
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      $display("[TB] back-to-back swap front=%b done=%b", front_bank, swap_done);
      n_tests++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b exp=1", swap_done); end
      n_tests++; if (front_bank !== 1'b1) begin n_fail++; $display("FAIL b2b_front got=%b exp=1", front_bank); end
      // read accepted in the swap_done cycle still sees the old front bank
      s2_rd(4'd9, v, d);
      n_tests++; if (d !== 16'h2222 || v !== 1'b1) begin n_fail++; $display("FAIL b2b_old_map got=%h/%b exp=2222/1", d, v); end
      n_tests++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end got=%b exp=0", swap_done); end
      wait_clear(cyc);
      n_tests++; if (cyc !== EXP_CLR1) begin n_fail++; $display("FAIL b2b_clear_len got=%0d exp=%0d", cyc, EXP_CLR1); end
      s2_rd(4'd9, v, d);
      n_tests++; if (d !== 16'h1111) begin n_fail++; $display("FAIL b2b_new_map got=%h exp=1111", d); end
   endtask

   task automatic test_reset_mid();
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      n_tests++; if (swap_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pending got=%b exp=1", swap_busy); end
      reset = 1'b1; tick(); reset = 1'b0;
      $display("[TB] reset in PENDING busy=%b front=%b", swap_busy, front_bank);
      n_tests++; if (swap_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", swap_busy); end
      n_tests++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL rmid_front got=%b exp=0", front_bank); end
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      n_tests++; if (swap_done !== 1'b0 || front_bank !== 1'b0) begin n_fail++; $display("FAIL rmid_fd done=%b front=%b exp 0 0", swap_done, front_bank); end
   endtask

`ifdef FRAMEBUF_CLEAR_EN
   task automatic test_clear();
      logic v; logic [DW-1:0] d; int cyc;
      s1_wr(4'd0, 16'hBEEF, 2'b11);
      s1_wr(4'd6, 16'h0F0F, 2'b11);
      s1_wr(4'd15, 16'hFFFF, 2'b11);
      do_swap();
      wait_clear(cyc);
      n_tests++; if (cyc !== 16) begin n_fail++; $display("FAIL clr1_len got=%0d exp=16", cyc); end
      do_swap();
      n_tests++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL clr2_front got=%b exp=0", front_bank); end
      wait_clear(cyc);
      n_tests++; if (cyc !== 16) begin n_fail++; $display("FAIL clr2_len got=%0d exp=16", cyc); end
      for (int a = 0; a < 16; a++) begin
         s1_rd(AW'(a), v, d);
         n_tests++; if (d !== 16'h0 || v !== 1'b1) begin n_fail++; $display("FAIL clr_word[%0d] got=%h/%b exp=0000/1", a, d, v); end
      end
   endtask

   task automatic test_clear_reset();
      do_swap();
      tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      $display("[TB] reset in 3rd clear cycle wait=%b busy=%b front=%b", s1_waitrequest, swap_busy, front_bank);
      n_tests++; if (s1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL crst_wait got=%b exp=0", s1_waitrequest); end
      n_tests++; if (swap_busy !== 1'b0) begin n_fail++; $display("FAIL crst_busy got=%b exp=0", swap_busy); end
      n_tests++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL crst_front got=%b exp=0", front_bank); end
      tick();
      n_tests++; if (s1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL crst_abort got=%b exp=0", s1_waitrequest); end
   endtask
`endif

   initial begin
      test_reset();
      test_bank_isolation();
      test_swap();
      test_byteenable();
      test_same_cycle();
      test_back_to_back();
      test_reset_mid();
`ifdef FRAMEBUF_CLEAR_EN
      test_clear();
      test_clear_reset();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/framebuf_pingpong.md
# framebuf_pingpong

Parametrised double-buffered voxel frame buffer. The renderer writes the back bank through Avalon-MM slave s1 while the display scanner reads the front bank through slave s2. A swap requested by the renderer takes effect only at the scanner's frame boundary, so a displayed frame is never torn. It replaces the single-bank dual-port frame RAM between the Nios renderer and the LED/voxel scan engine.

## Interface
- DATA_W, 16, word width in bits; multiple of 8.
- ADDR_W, 13, word address width per bank; each bank holds 2^ADDR_W words.
- BE_W, DATA_W/8, byte-enable width; derived, not overridden.
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- s1_address  in  ADDR_W  writer word address into the back bank.
- s1_chipselect, s1_write, s1_read  in  1  writer strobes.
- s1_byteenable  in  BE_W  writer byte lanes.
- s1_writedata  in  DATA_W  write data.
- s1_readdata  out  DATA_W  back-bank read data.
- s1_readdatavalid  out  1  s1_readdata qualifier.
- s1_waitrequest  out  1  writer stall.
- s2_address  in  ADDR_W  scanner word address into the front bank.
- s2_chipselect, s2_read  in  1  scanner strobes.
- s2_readdata  out  DATA_W  front-bank read data.
- s2_readdatavalid  out  1  s2_readdata qualifier.
- swap_req  in  1  renderer one-cycle pulse: back frame complete.
- frame_done  in  1  scanner one-cycle pulse: last word of frame consumed.
- swap_busy  out  1  swap pending or clearing; swap_req ignored.
- swap_done  out  1  one-cycle pulse in the cycle front_bank toggles.
- front_bank  out  1  bank index currently displayed.

## Operation
- Storage: one true-dual-port RAM of 2^(ADDR_W+1) words. Physical address = {bank, address}. s1 uses ~front_bank and s2 uses front_bank.
- Bank is sampled in the cycle a command is accepted. A command accepted in the swap_done cycle uses the old mapping.
- s1 accept = chipselect & ~waitrequest & (write | read). Write honours byteenable. Write and read in the same cycle: the write wins and the read is dropped.
- s2 accept = chipselect & read; s2 never stalls.
- FSM states: IDLE, PENDING, CLEAR.
  - IDLE: swap_req -> PENDING.
  - PENDING: frame_done -> toggle front_bank, pulse swap_done; go to CLEAR if FRAMEBUF_CLEAR_EN is defined, otherwise IDLE.
  - CLEAR: counter runs 0..2^ADDR_W-1 and writes zero to the new back bank, one word per cycle. At terminal count -> IDLE.
- swap_busy = (state != IDLE).
- swap_req outside IDLE is ignored.
- frame_done outside PENDING is ignored.
- swap_req and frame_done in the same IDLE cycle: the request is captured and the swap waits for the next frame_done.
- Reset mid-operation: FSM to IDLE, front_bank 0, clear aborted. Memory contents are untouched, and no reset initialisation of the RAM is performed.
- Reset values: readdata both 0, readdatavalid both 0, s1_waitrequest 0, swap_busy 0, swap_done 0, front_bank 0.

## Timing
- Read latency is fixed at 1 on both ports. readdatavalid is high in the cycle after accept. readdata is registered and holds its last value otherwise.
- Same-address s1 write and s2 read cannot collide, because the ports are on different banks.
- s1 read-during-write to the same address returns old data.
- swap_done and the front_bank toggle occur in the cycle after frame_done is sampled in PENDING.
- PENDING lasts at least one cycle, even when frame_done arrives the cycle after swap_req.
- s1_waitrequest is high exactly while in CLEAR, for 2^ADDR_W cycles.

## Configuration
- FRAMEBUF_CLEAR_EN defined:
  - CLEAR state and clear counter are present.
  - The new back bank reads all-zero before the renderer regains access.
  - s1_waitrequest is asserted during the clear.
- FRAMEBUF_CLEAR_EN undefined:
  - No CLEAR state and no counter.
  - s1_waitrequest is tied 0.
  - The back bank retains the frame displayed before the swap.

## Structure
- Package framebuf_pkg holds:
  - FSM state enum (FB_IDLE, FB_PENDING, FB_CLEAR);
  - default DATA_W/ADDR_W constants;
  - a bank-address concatenation function.
- One sub-module, framebuf_tdp_ram: inferred true-dual-port RAM with byte enables and a registered output. The FSM, clear counter and port muxing stay in the top level.

## Test plan
- After reset: s1 writes 0xA5A5 at address 5, then s2 reads address 5 -> bank 0 data (not 0xA5A5); s1 reads address 5 -> 0xA5A5 with readdatavalid one cycle later.
- swap_req then frame_done 10 cycles later -> swap_busy high for the gap, swap_done pulse, front_bank=1; s2 read of address 5 -> 0xA5A5.
- Byte enable 2'b01 write of 0x1234 over 0xA5A5 -> readback 0xA534.
- swap_req and frame_done in the same cycle -> no swap; the next frame_done swaps; a second swap_req while PENDING is ignored.
- FRAMEBUF_CLEAR_EN with ADDR_W=4: swap -> s1_waitrequest high for exactly 16 cycles, then all 16 back-bank words read 0.
- Reset asserted in the 3rd clear cycle -> next cycle state IDLE, waitrequest 0, front_bank 0.
